// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller.
// Holds the FSM state enum, vector/index sizing, the settle counter width
// and the default golden response for z = (a & ~c) ^ (b & c).
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MAX_SETTLE  = 15;

  localparam logic [NUM_VECTORS-1:0] GOLDEN_DEFAULT = 8'hD8;

  // Lowest set bit position of a mask; 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_VECTORS-1:0] mask);
    logic [IDX_W-1:0] pos;
    pos = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (mask[i]) pos = IDX_W'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// sweep_settle_timer: loadable down-counter pacing each sweep vector.
// Ports: clk, rst_n (async active-low), load (restart the window),
// en (count while sweeping), expire_c (combinational strobe on the last
// cycle of each SETTLE_CYCLES+1 window; the counter reloads itself).
module sweep_settle_timer
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);

  // Counter is only 4 bits wide; larger settle values cannot be represented.
  generate
    if (SETTLE_CYCLES > MAX_SETTLE) begin : g_settle_range
      $error("sweep_settle_timer: SETTLE_CYCLES must be in 0..15");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_c = en && (cnt_q == '0);

  // Reload at window start and on every expiry so back-to-back windows tile.
  always_comb begin
    cnt_d = cnt_q;
    if (load || expire_c) begin
      cnt_d = RELOAD;
    end else if (en) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive self-test sequencer for the external 3-input
// gate. On start it steps {a,b,c} through 000..111, holds each vector for
// SETTLE_CYCLES+1 cycles, samples z into result[idx], then compares against
// EXPECTED and pulses done for one cycle.
// Ports: clk, rst_n (async active-low); start, abort (requests);
// a, b, c (registered gate drive); z (gate output); busy, done, result,
// pass, mismatch (registered status).
// Optional macro GATE_SWEEP_FIRST_FAIL_EN adds first_fail[2:0] (lowest
// mismatching vector) and fail_seen (sticky per-sweep miscompare flag).
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned                 SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0]      EXPECTED      = GOLDEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  input  logic                   z,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] result,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] mismatch
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  ,
  output logic [IDX_W-1:0]       first_fail,
  output logic                   fail_seen
`endif
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [2:0]             abc_q, abc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [NUM_VECTORS-1:0] result_q, result_d;
  logic [NUM_VECTORS-1:0] mismatch_q, mismatch_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic [IDX_W-1:0]       first_fail_q, first_fail_d;
  logic                   fail_seen_q, fail_seen_d;
`endif

  logic timer_load_c;
  logic timer_en_c;
  logic sample_c;

  assign timer_en_c = (state_q == RUN);

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_c),
    .en       (timer_en_c),
    .expire_c (sample_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    abc_d        = abc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    result_d     = result_q;
    mismatch_d   = mismatch_q;
    timer_load_c = 1'b0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
`endif

    unique case (state_q)
      IDLE: begin
        // abort is meaningless here, so a simultaneous start still launches.
        if (start) begin
          state_d      = RUN;
          idx_d        = '0;
          abc_d        = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          result_d     = '0;
          mismatch_d   = '0;
          timer_load_c = 1'b1;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
`endif
        end
      end

      RUN: begin
        if (abort) begin
          // Partial samples stay in result; no verdict is issued.
          state_d = IDLE;
          abc_d   = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (sample_c) begin
          result_d[idx_q] = z;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
          if (z != EXPECTED[idx_q]) fail_seen_d = 1'b1;
`endif
          if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
            state_d    = FINISH;
            abc_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = (result_d == EXPECTED);
            mismatch_d = result_d ^ EXPECTED;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            first_fail_d = lowest_set(result_d ^ EXPECTED);
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
            abc_d = idx_q + IDX_W'(1);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      abc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      result_q     <= '0;
      mismatch_q   <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      abc_q        <= abc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      result_q     <= result_d;
      mismatch_q   <= mismatch_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
`endif
    end
  end

  assign a        = abc_q[2];
  assign b        = abc_q[1];
  assign c        = abc_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign result   = result_q;
  assign mismatch = mismatch_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;
`endif

endmodule
